// File: rtl/lane_issue_buffer_if.sv
// Dispatch, wakeup and issue signals of one lane issue buffer.
// Signal suffixes are from the buffer's point of view.
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

interface lane_issue_buffer_if #(
  parameter int TAG_W     = `SIZE_PHYSICAL_LOG,
  parameter int PAYLOAD_W = 64,
  parameter int WAKE_N    = `ISSUE_WIDTH
);
  logic                    dispValid_i;
  logic [PAYLOAD_W-1:0]    dispPayload_i;
  logic [TAG_W-1:0]        dispSrc1_i;
  logic [TAG_W-1:0]        dispSrc2_i;
  logic                    dispSrc1Rdy_i;
  logic                    dispSrc2Rdy_i;
  logic [TAG_W-1:0]        dispDest_i;
  logic                    dispReady_o;

  logic [WAKE_N-1:0]       wakeValid_i;
  logic [WAKE_N*TAG_W-1:0] wakeTag_i;

  logic                    issueValid_o;
  logic [PAYLOAD_W-1:0]    issuePayload_o;
  logic [TAG_W-1:0]        issueSrc1_o;
  logic [TAG_W-1:0]        issueSrc2_o;
  logic [TAG_W-1:0]        issueDest_o;
  logic                    stall_i;

  // Upstream dispatch / wakeup / execution-pipe side.
  modport master (
    output dispValid_i, dispPayload_i, dispSrc1_i, dispSrc2_i,
           dispSrc1Rdy_i, dispSrc2Rdy_i, dispDest_i,
           wakeValid_i, wakeTag_i, stall_i,
    input  dispReady_o, issueValid_o, issuePayload_o,
           issueSrc1_o, issueSrc2_o, issueDest_o
  );

  // Buffer side.
  modport slave (
    input  dispValid_i, dispPayload_i, dispSrc1_i, dispSrc2_i,
           dispSrc1Rdy_i, dispSrc2Rdy_i, dispDest_i,
           wakeValid_i, wakeTag_i, stall_i,
    output dispReady_o, issueValid_o, issuePayload_o,
           issueSrc1_o, issueSrc2_o, issueDest_o
  );
endinterface

// File: rtl/lane_issue_buffer.sv
// Collapsing in-order-age issue buffer for one execution lane: entries wait
// for both source tags to be woken, oldest ready entry issues into a register.
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

module lane_issue_buffer #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = `SIZE_PHYSICAL_LOG,
  parameter int PAYLOAD_W = 64,
  parameter int WAKE_N    = `ISSUE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     recoverFlag_i,
  input  logic                     laneActive_i,
  lane_issue_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                 valid;
    logic                 rdy1;
    logic                 rdy2;
    logic [TAG_W-1:0]     src1;
    logic [TAG_W-1:0]     src2;
    logic [TAG_W-1:0]     dest;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t               entry_q [DEPTH];
  entry_t               entry_d [DEPTH];
  entry_t               woken   [DEPTH];
  entry_t               shifted [DEPTH];
  entry_t               disp_entry;

  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     wr_idx;

  logic                 iss_valid_q;
  logic [PAYLOAD_W-1:0] iss_payload_q;
  logic [TAG_W-1:0]     iss_src1_q, iss_src2_q, iss_dest_q;

  logic                 disp_ready, disp_fire;
  logic                 sel_en, sel_found, issue_fire;
  logic [IDX_W-1:0]     sel_idx;

  function automatic logic tag_woken(input logic [TAG_W-1:0]        tag,
                                     input logic [WAKE_N-1:0]       vld,
                                     input logic [WAKE_N*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_N; k++) begin
      if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  // Dispatch sees only the registered count; a same-cycle issue frees nothing.
  assign disp_ready = reset && laneActive_i && (count_q < CNT_W'(DEPTH));
  assign disp_fire  = bus.dispValid_i && disp_ready;
  assign sel_en     = laneActive_i && !(iss_valid_q && bus.stall_i);
  assign issue_fire = sel_en && sel_found;
  assign wr_idx     = count_q - CNT_W'(issue_fire);
  assign count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);

  // Oldest-first pick over ready state registered at the start of the cycle.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entry_q[i].valid && entry_q[i].rdy1 && entry_q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.src1    = bus.dispSrc1_i;
    disp_entry.src2    = bus.dispSrc2_i;
    disp_entry.dest    = bus.dispDest_i;
    disp_entry.payload = bus.dispPayload_i;
    disp_entry.rdy1    = bus.dispSrc1Rdy_i ||
                         tag_woken(bus.dispSrc1_i, bus.wakeValid_i, bus.wakeTag_i);
    disp_entry.rdy2    = bus.dispSrc2Rdy_i ||
                         tag_woken(bus.dispSrc2_i, bus.wakeValid_i, bus.wakeTag_i);
  end

  // Wakeups apply to every entry, independent of laneActive_i; ready bits
  // only ever accumulate.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]      = entry_q[i];
      woken[i].rdy1 = entry_q[i].rdy1 ||
                      tag_woken(entry_q[i].src1, bus.wakeValid_i, bus.wakeTag_i);
      woken[i].rdy2 = entry_q[i].rdy2 ||
                      tag_woken(entry_q[i].src2, bus.wakeValid_i, bus.wakeTag_i);
    end
  end

  // Each slot's upper neighbour, used when the collapse moves entries down.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) shifted[i] = '0;
    for (int i = 0; i < DEPTH - 1; i++) shifted[i] = woken[i + 1];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && IDX_W'(i) >= sel_idx) entry_d[i] = shifted[i];
      else                                    entry_d[i] = woken[i];
      if (disp_fire && CNT_W'(i) == wr_idx)   entry_d[i] = disp_entry;
    end
  end

  // NOTE: only valid and ready bits are reset; tag and payload storage is
  // don't-care while an entry is invalid, so it is left without reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].valid <= 1'b0;
        entry_q[i].rdy1  <= 1'b0;
        entry_q[i].rdy2  <= 1'b0;
      end
    end else if (recoverFlag_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].valid <= 1'b0;
        entry_q[i].rdy1  <= 1'b0;
        entry_q[i].rdy2  <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      entry_q <= entry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q       <= '0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_src1_q    <= '0;
      iss_src2_q    <= '0;
      iss_dest_q    <= '0;
    end else if (recoverFlag_i) begin
      count_q     <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (issue_fire) begin
        iss_valid_q   <= 1'b1;
        iss_payload_q <= entry_q[sel_idx].payload;
        iss_src1_q    <= entry_q[sel_idx].src1;
        iss_src2_q    <= entry_q[sel_idx].src2;
        iss_dest_q    <= entry_q[sel_idx].dest;
      end else if (!(iss_valid_q && bus.stall_i)) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  assign bus.dispReady_o    = disp_ready;
  assign bus.issueValid_o   = iss_valid_q;
  assign bus.issuePayload_o = iss_payload_q;
  assign bus.issueSrc1_o    = iss_src1_q;
  assign bus.issueSrc2_o    = iss_src2_q;
  assign bus.issueDest_o    = iss_dest_q;
  assign count_o            = count_q;

endmodule

// File: tb/tb_lane_issue_buffer.sv
// Directed bench for lane_issue_buffer: stimulus pushes expected issue packets
// in hand-derived issue order; a negedge monitor pops them as the pipe consumes.
module tb_lane_issue_buffer;
  localparam int DEPTH     = 8;
  localparam int TAG_W     = 7;
  localparam int PAYLOAD_W = 64;
  localparam int WAKE_N    = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  recoverFlag_i = 1'b0;
  logic                  laneActive_i = 1'b0;
  logic [$clog2(DEPTH):0] count_o;

  lane_issue_buffer_if #(.TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .WAKE_N(WAKE_N)) bus ();

  lane_issue_buffer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .WAKE_N(WAKE_N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .recoverFlag_i (recoverFlag_i),
    .laneActive_i  (laneActive_i),
    .bus           (bus),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PAYLOAD_W-1:0] payload;
    logic [TAG_W-1:0]     s1;
    logic [TAG_W-1:0]     s2;
    logic [TAG_W-1:0]     d;
  } pkt_t;

  pkt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dispValid_i   = 1'b0;
    bus.dispPayload_i = '0;
    bus.dispSrc1_i    = '0;
    bus.dispSrc2_i    = '0;
    bus.dispSrc1Rdy_i = 1'b0;
    bus.dispSrc2Rdy_i = 1'b0;
    bus.dispDest_i    = '0;
    bus.wakeValid_i   = '0;
    bus.wakeTag_i     = '0;
    bus.stall_i       = 1'b0;
  endtask

  task automatic set_disp(input logic [63:0] p, input logic [TAG_W-1:0] s1, input logic r1,
                          input logic [TAG_W-1:0] s2, input logic r2, input logic [TAG_W-1:0] d);
    bus.dispValid_i   = 1'b1;
    bus.dispPayload_i = p;
    bus.dispSrc1_i    = s1;
    bus.dispSrc1Rdy_i = r1;
    bus.dispSrc2_i    = s2;
    bus.dispSrc2Rdy_i = r2;
    bus.dispDest_i    = d;
  endtask

  task automatic clr_disp();
    bus.dispValid_i = 1'b0;
  endtask

  task automatic set_wake(input int port, input logic [TAG_W-1:0] tag);
    bus.wakeValid_i[port]              = 1'b1;
    bus.wakeTag_i[port*TAG_W +: TAG_W] = tag;
  endtask

  task automatic clr_wake();
    bus.wakeValid_i = '0;
    bus.wakeTag_i   = '0;
  endtask

  task automatic push_exp(input logic [63:0] p, input logic [TAG_W-1:0] s1,
                          input logic [TAG_W-1:0] s2, input logic [TAG_W-1:0] d);
    pkt_t e;
    e.payload = p;
    e.s1 = s1;
    e.s2 = s2;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // A packet is consumed on an edge where it is valid and the pipe is not stalled.
  initial begin
    forever begin
      pkt_t e;
      @(negedge clk);
      if (bus.issueValid_o === 1'b1 && bus.stall_i === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got payload %0h, expected no issue", bus.issuePayload_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_payload", bus.issuePayload_o, e.payload);
          check("sb_src1", 64'(bus.issueSrc1_o), 64'(e.s1));
          check("sb_src2", 64'(bus.issueSrc2_o), 64'(e.s2));
          check("sb_dest", 64'(bus.issueDest_o), 64'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    laneActive_i = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    check("rst_count", 64'(count_o), 0);
    check("rst_issue_valid", 64'(bus.issueValid_o), 0);
    check("rst_disp_ready", 64'(bus.dispReady_o), 0);
    check("rst_issue_payload", bus.issuePayload_o, 0);
    reset = 1'b1;
    #1;
    check("post_rst_disp_ready", 64'(bus.dispReady_o), 1);
    tick();

    // Single ready dispatch: visible on issue two cycles later.
    set_disp(64'hA0A0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd3);
    push_exp(64'hA0A0, 7'd1, 7'd2, 7'd3);
    tick();
    clr_disp();
    check("a_c1_count", 64'(count_o), 1);
    check("a_c1_valid", 64'(bus.issueValid_o), 0);
    tick();
    check("a_c2_valid", 64'(bus.issueValid_o), 1);
    check("a_c2_payload", bus.issuePayload_o, 64'hA0A0);
    check("a_c2_count", 64'(count_o), 0);
    tick();
    tick();

    // Younger ready entry bypasses an older waiting one.
    set_disp(64'hB0B0, 7'd5, 1'b0, 7'd6, 1'b1, 7'd7);
    tick();
    set_disp(64'hC0C0, 7'd10, 1'b1, 7'd11, 1'b1, 7'd12);
    push_exp(64'hC0C0, 7'd10, 7'd11, 7'd12);
    push_exp(64'hB0B0, 7'd5, 7'd6, 7'd7);
    tick();
    clr_disp();
    tick();
    check("bc_c3_valid", 64'(bus.issueValid_o), 1);
    check("bc_c3_payload", bus.issuePayload_o, 64'hC0C0);
    tick();
    check("bc_c4_valid", 64'(bus.issueValid_o), 0);
    check("bc_c4_count", 64'(count_o), 1);
    set_wake(0, 7'd5);
    tick();
    clr_wake();
    check("bc_c5_valid", 64'(bus.issueValid_o), 0);
    tick();
    check("bc_c6_valid", 64'(bus.issueValid_o), 1);
    check("bc_c6_payload", bus.issuePayload_o, 64'hB0B0);
    check("bc_c6_count", 64'(count_o), 0);
    tick();
    tick();

    // Wakeup in the dispatch cycle on the second broadcast port.
    set_disp(64'h3535, 7'd13, 1'b1, 7'd9, 1'b0, 7'd14);
    set_wake(1, 7'd9);
    push_exp(64'h3535, 7'd13, 7'd9, 7'd14);
    tick();
    clr_disp();
    clr_wake();
    check("w_c1_valid", 64'(bus.issueValid_o), 0);
    check("w_c1_count", 64'(count_o), 1);
    tick();
    check("w_c2_valid", 64'(bus.issueValid_o), 1);
    check("w_c2_payload", bus.issuePayload_o, 64'h3535);
    tick();
    tick();

    // Stall holds the issue register and blocks further selection.
    set_disp(64'hD0D0, 7'd15, 1'b1, 7'd16, 1'b1, 7'd17);
    push_exp(64'hD0D0, 7'd15, 7'd16, 7'd17);
    tick();
    set_disp(64'hE0E0, 7'd18, 1'b1, 7'd19, 1'b1, 7'd1);
    push_exp(64'hE0E0, 7'd18, 7'd19, 7'd1);
    tick();
    clr_disp();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(bus.issueValid_o), 1);
      check("stall_payload", bus.issuePayload_o, 64'hD0D0);
      check("stall_dest", 64'(bus.issueDest_o), 64'd17);
      check("stall_count", 64'(count_o), 1);
      tick();
    end
    bus.stall_i = 1'b0;
    check("unstall_payload", bus.issuePayload_o, 64'hD0D0);
    tick();
    check("after_stall_payload", bus.issuePayload_o, 64'hE0E0);
    check("after_stall_count", 64'(count_o), 0);
    tick();
    tick();

    // Fill with entries that are not ready; the ninth dispatch is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(64'h100 + 64'(i), 7'(20 + i), 1'b0, 7'd40, 1'b1, 7'(i));
      tick();
    end
    clr_disp();
    check("full_count", 64'(count_o), 8);
    check("full_disp_ready", 64'(bus.dispReady_o), 0);
    set_disp(64'h1FF, 7'd50, 1'b1, 7'd51, 1'b1, 7'd52);
    tick();
    clr_disp();
    check("ninth_ignored_count", 64'(count_o), 8);

    // Two oldest woken together issue in age order.
    set_wake(0, 7'd20);
    set_wake(1, 7'd21);
    push_exp(64'h100, 7'd20, 7'd40, 7'd0);
    push_exp(64'h101, 7'd21, 7'd40, 7'd1);
    tick();
    clr_wake();
    for (int i = 0; i < 4; i++) tick();
    check("drain2_count", 64'(count_o), 6);

    // Youngest entry issues from the top of the queue.
    set_wake(0, 7'd27);
    push_exp(64'h107, 7'd27, 7'd40, 7'd7);
    tick();
    clr_wake();
    for (int i = 0; i < 3; i++) tick();
    check("top_issue_count", 64'(count_o), 5);

    // Inactive lane: no selection, no dispatch, wakeups still recorded.
    laneActive_i = 1'b0;
    set_wake(0, 7'd23);
    set_disp(64'h2AA, 7'd1, 1'b1, 7'd2, 1'b1, 7'd3);
    #1;
    check("inactive_disp_ready", 64'(bus.dispReady_o), 0);
    tick();
    clr_wake();
    tick();
    tick();
    check("inactive_valid", 64'(bus.issueValid_o), 0);
    check("inactive_count", 64'(count_o), 5);
    clr_disp();
    laneActive_i = 1'b1;
    push_exp(64'h103, 7'd23, 7'd40, 7'd3);
    for (int i = 0; i < 3; i++) tick();
    check("reactivate_count", 64'(count_o), 4);

    set_disp(64'h108, 7'd30, 1'b0, 7'd40, 1'b1, 7'd8);
    tick();
    clr_disp();
    check("five_count", 64'(count_o), 5);

    // Flush alongside a dispatch: everything, including the new entry, is gone.
    recoverFlag_i = 1'b1;
    set_disp(64'h3CC, 7'd1, 1'b1, 7'd2, 1'b1, 7'd3);
    tick();
    recoverFlag_i = 1'b0;
    clr_disp();
    check("flush_count", 64'(count_o), 0);
    check("flush_valid", 64'(bus.issueValid_o), 0);
    set_wake(0, 7'd22);
    set_wake(1, 7'd30);
    tick();
    clr_wake();
    for (int i = 0; i < 3; i++) tick();
    check("flush_empty_valid", 64'(bus.issueValid_o), 0);
    check("flush_empty_count", 64'(count_o), 0);

    // Flush clears a stalled issue register.
    set_disp(64'h4DD, 7'd1, 1'b1, 7'd2, 1'b1, 7'd3);
    tick();
    clr_disp();
    bus.stall_i = 1'b1;
    tick();
    check("flush_iss_pre_valid", 64'(bus.issueValid_o), 1);
    recoverFlag_i = 1'b1;
    tick();
    recoverFlag_i = 1'b0;
    bus.stall_i = 1'b0;
    check("flush_iss_valid", 64'(bus.issueValid_o), 0);
    check("flush_iss_count", 64'(count_o), 0);

    // Reset wins over a pending selection and a flush.
    set_disp(64'h5EE, 7'd4, 1'b1, 7'd5, 1'b1, 7'd6);
    tick();
    clr_disp();
    reset = 1'b0;
    recoverFlag_i = 1'b1;
    tick();
    check("rst2_valid", 64'(bus.issueValid_o), 0);
    check("rst2_count", 64'(count_o), 0);
    check("rst2_disp_ready", 64'(bus.dispReady_o), 0);
    check("rst2_payload", bus.issuePayload_o, 0);
    reset = 1'b1;
    recoverFlag_i = 1'b0;
    tick();
    tick();
    check("rst2_after_valid", 64'(bus.issueValid_o), 0);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
